// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: register-driven SD card CMD line transceiver.
// Frames a 48-bit command (start, dir, index, ARG, CRC7, end), shifts it out
// on sd_clk falling edges, optionally captures a 48-bit response on rising
// edges, checks its CRC7/end bit and reports status.
// Ports:
//   clk, reset               system clock, async active-high reset
//   address/chipselect/
//   write_n/writedata        Avalon-MM slave write side
//   readdata                 registered read data (1 clk latency)
//   sd_clk                   free-running SD clock (period 2*CLK_DIV clk)
//   cmd_out/cmd_oe/cmd_in    CMD pad tristate controls
// Registers: 0 ARG (R/W), 1 CMD (W: [5:0] index, [6] resp_en),
//            2 STATUS ([0] busy, [1] timeout, [2] crc_err, [13:8] resp index),
//            3 RESP (response bits [39:8]).
module sd_cmd_engine #(
    parameter int CLK_DIV      = 4,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    output logic        cmd_out,
    output logic        cmd_oe,
    input  logic        cmd_in
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam int TW = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(RESP_TIMEOUT - 1);

    // CRC7, poly x^7+x^3+1, init 0, over a 40-bit MSB-first stream.
    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    logic [DW-1:0] div_cnt;
    logic          fall_tick, rise_tick;
    logic [2:0]    state;
    logic [31:0]   arg, resp;
    logic [5:0]    resp_idx;
    logic          timeout, crc_err, resp_en;
    logic [47:0]   tx_sr;
    logic [46:0]   rx_sr;
    logic [47:0]   rx_word;
    logic [39:0]   tx_head;
    logic [5:0]    bit_cnt;
    logic [TW-1:0] wait_cnt;
    logic [2:0]    gap_cnt;
    logic          wr, launch, busy;
    logic [31:0]   rd_mux;

    // Ticks are decoded from the cycle in which sd_clk is about to toggle, so
    // pad updates land on the same clk edge as the sd_clk transition.
    assign fall_tick = (div_cnt == DIV_LAST) &&  sd_clk;
    assign rise_tick = (div_cnt == DIV_LAST) && !sd_clk;

    assign busy    = (state != S_IDLE);
    assign wr      = chipselect && !write_n;
    assign launch  = wr && (address == 2'd1) && !busy;
    assign tx_head = {2'b01, writedata[5:0], arg};
    assign rx_word = {rx_sr, cmd_in};

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = arg;
            2'd2:    rd_mux = {18'b0, resp_idx, 5'b0, crc_err, timeout, busy};
            2'd3:    rd_mux = resp;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            arg      <= '0;
        end else begin
            readdata <= rd_mux;
            if (wr && (address == 2'd0) && !busy) arg <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cmd_out  <= 1'b1;
            cmd_oe   <= 1'b0;
            resp     <= '0;
            resp_idx <= '0;
            timeout  <= 1'b0;
            crc_err  <= 1'b0;
            resp_en  <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        tx_sr   <= {tx_head, crc7_40(tx_head), 1'b1};
                        resp_en <= writedata[6];
                        timeout <= 1'b0;
                        crc_err <= 1'b0;
                        bit_cnt <= '0;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (fall_tick) begin
                        if (bit_cnt < 6'd48) begin
                            cmd_oe  <= 1'b1;
                            cmd_out <= tx_sr[47];
                            tx_sr   <= {tx_sr[46:0], 1'b1};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            // end bit has been on the line for a full period
                            cmd_oe   <= 1'b0;
                            cmd_out  <= 1'b1;
                            wait_cnt <= '0;
                            gap_cnt  <= '0;
                            state    <= resp_en ? S_WAIT : S_GAP;
                        end
                    end
                end
                S_WAIT: begin
                    if (rise_tick) begin
                        if (!cmd_in) begin
                            rx_sr   <= {rx_sr[45:0], cmd_in};
                            bit_cnt <= 6'd1;
                            state   <= S_RECV;
                        end else if (wait_cnt == TO_LAST) begin
                            timeout <= 1'b1;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (rise_tick) begin
                        if (bit_cnt == 6'd47) begin
                            // rx_word includes the bit being sampled now
                            resp     <= rx_word[39:8];
                            resp_idx <= rx_word[45:40];
                            crc_err  <= !rx_word[0] ||
                                        ((rx_word[45:40] != 6'h3F) &&
                                         (crc7_40(rx_word[47:8]) != rx_word[7:1]));
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end else begin
                            rx_sr   <= {rx_sr[45:0], cmd_in};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (rise_tick) begin
                        if (gap_cnt == 3'd7) state <= S_IDLE;
                        else                 gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: register access, command framing,
// response capture/CRC checking, timeout, GAP timing and async reset.
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sd_clk;
    logic        cmd_out;
    logic        cmd_oe;
    logic        cmd_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_cmd_engine #(.CLK_DIV(4), .RESP_TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .sd_clk     (sd_clk),
        .cmd_out    (cmd_out),
        .cmd_oe     (cmd_oe),
        .cmd_in     (cmd_in)
    );

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Bus tasks are entered at a negedge of clk and return at a negedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    // Collect cmd_out at each sd_clk rise while cmd_oe is high.
    task automatic capture(output logic [47:0] f, output int n);
        int g;
        g = 0; f = '0; n = 0;
        while (cmd_oe !== 1'b1 && g < 200) begin
            @(negedge clk); g++;
        end
        if (cmd_oe !== 1'b1) begin
            checks++; failures++;
            $display("FAIL capture_start cmd_oe=%b required 1 within 200 clk", cmd_oe);
            return;
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge sd_clk);
            if (cmd_oe === 1'b1) begin
                f = {f[46:0], cmd_out};
                n++;
            end else break;
        end
        @(negedge clk);
    endtask

    // Card model: drive a 48-bit reply, changing on sd_clk falling edges.
    task automatic reply(input logic [47:0] r, input int dly);
        repeat (dly) @(posedge sd_clk);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sd_clk);
            cmd_in = r[i];
        end
        @(negedge sd_clk);
        cmd_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        bit          done;
        done = 0;
        for (int g = 0; g < 3000 && !done; g++) begin
            bus_read(2'd2, d);
            if (d[0] === 1'b0) done = 1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL wait_idle busy=1 required 0 within 3000 reads");
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if ({readdata, sd_clk, cmd_out, cmd_oe} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_pins rd=%h sd_clk=%b out=%b oe=%b required 0/0/1/0",
                     readdata, sd_clk, cmd_out, cmd_oe);
        end
        @(negedge clk); reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_read(a[1:0], d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h required=00000000", a, d);
            end
        end
    endtask

    task automatic test_clock();
        int   edges[$];
        logic prev;
        prev = sd_clk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sd_clk !== prev) begin
                edges.push_back(i);
                prev = sd_clk;
            end
        end
        checks++;
        if (edges.size() < 3) begin
            failures++;
            $display("FAIL sd_clk_toggle edges=%0d required >=3", edges.size());
        end else if (edges[1] - edges[0] != 4 || edges[2] - edges[1] != 4) begin
            failures++;
            $display("FAIL sd_clk_half_period got=%0d,%0d required=4,4",
                     edges[1] - edges[0], edges[2] - edges[1]);
        end
    endtask

    task automatic test_cmd0_no_resp();
        logic [47:0] f;
        int          n;
        logic [31:0] d;
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h00);
        bus_read(2'd2, d);
        checks++;
        if (d[0] !== 1'b1) begin
            failures++;
            $display("FAIL cmd0_busy_after_launch got=%b required=1", d[0]);
        end
        bus_read(2'd1, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL cmd_reg_read got=%h required=00000000", d);
        end
        capture(f, n);
        checks++;
        if (f !== 48'h40_00000000_95 || n != 48) begin
            failures++;
            $display("FAIL cmd0_frame got=%h/%0d required=400000000095/48", f, n);
        end
        // capture returns just after GAP rise 1; busy must hold through rise 7
        repeat (6) @(posedge sd_clk);
        @(negedge clk);
        bus_read(2'd2, d);
        checks++;
        if (d[0] !== 1'b1) begin
            failures++;
            $display("FAIL gap_busy_rise7 got=%b required=1", d[0]);
        end
        @(posedge sd_clk);
        @(negedge clk);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL cmd0_status_after_gap got=%h required=00000000", d);
        end
    endtask

    task automatic test_cmd8_resp();
        logic [47:0] f;
        int          n;
        logic [31:0] d;
        bus_write(2'd0, 32'h000001AA);
        bus_write(2'd1, 32'h48);
        capture(f, n);
        checks++;
        if (f !== 48'h48_000001AA_87 || n != 48) begin
            failures++;
            $display("FAIL cmd8_frame got=%h/%0d required=48000001aa87/48", f, n);
        end
        reply(48'h08_000001AA_13, 4);
        wait_idle();
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h000001AA) begin
            failures++;
            $display("FAIL cmd8_resp got=%h required=000001aa", d);
        end
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h00000800) begin
            failures++;
            $display("FAIL cmd8_status got=%h required=00000800", d);
        end
    endtask

    task automatic test_crc_error();
        logic [47:0] f;
        int          n;
        logic [31:0] d;
        bus_write(2'd1, 32'h48);
        capture(f, n);
        reply(48'h08_000001AA_11, 4);
        wait_idle();
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h00000804) begin
            failures++;
            $display("FAIL crc_err_status got=%h required=00000804", d);
        end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h000001AA) begin
            failures++;
            $display("FAIL crc_err_resp got=%h required=000001aa", d);
        end
    endtask

    task automatic test_timeout();
        logic [47:0] f;
        int          n;
        logic [31:0] d;
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h77);
        capture(f, n);
        checks++;
        if (f !== 48'h77_00000000_65 || n != 48) begin
            failures++;
            $display("FAIL cmd55_frame got=%h/%0d required=770000000065/48", f, n);
        end
        // rise 1 already seen; after 61 more the limit of 64 is not yet reached
        repeat (61) @(posedge sd_clk);
        @(negedge clk);
        bus_read(2'd2, d);
        checks++;
        if (d[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early got=%b required=01", d[1:0]);
        end
        wait_idle();
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h00000802) begin
            failures++;
            $display("FAIL timeout_status got=%h required=00000802", d);
        end
    endtask

    task automatic test_busy_writes_and_reset();
        logic [47:0] f;
        int          n;
        logic [31:0] d;
        bus_write(2'd0, 32'h000001AA);
        bus_write(2'd1, 32'h48);
        fork
            capture(f, n);
            begin
                repeat (2) @(negedge clk);
                bus_write(2'd1, 32'h11);
                bus_write(2'd0, 32'hDEADBEEF);
            end
        join
        checks++;
        if (f !== 48'h48_000001AA_87 || n != 48) begin
            failures++;
            $display("FAIL busy_write_frame got=%h/%0d required=48000001aa87/48", f, n);
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h000001AA) begin
            failures++;
            $display("FAIL busy_write_arg got=%h required=000001aa", d);
        end
        repeat (3) @(posedge sd_clk);
        @(negedge clk);
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h00000801) begin
            failures++;
            $display("FAIL wait_status got=%h required=00000801", d);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({readdata, sd_clk, cmd_out, cmd_oe} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midwait_reset rd=%h sd_clk=%b out=%b oe=%b required 0/0/1/0",
                     readdata, sd_clk, cmd_out, cmd_oe);
        end
        @(negedge clk); reset = 1'b0;
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_status got=%h required=00000000", d);
        end
        bus_read(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_arg got=%h required=00000000", d);
        end
    endtask

    task automatic test_r3_and_end_bit();
        logic [47:0] f;
        int          n;
        logic [31:0] d;
        bus_write(2'd1, 32'h69);
        capture(f, n);
        reply(48'h3F_00FF8000_FF, 3);
        wait_idle();
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h00003F00) begin
            failures++;
            $display("FAIL r3_status got=%h required=00003f00", d);
        end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h00FF8000) begin
            failures++;
            $display("FAIL r3_resp got=%h required=00ff8000", d);
        end
        bus_write(2'd0, 32'h000001AA);
        bus_write(2'd1, 32'h48);
        capture(f, n);
        reply(48'h08_000001AA_12, 4);
        wait_idle();
        bus_read(2'd2, d);
        checks++;
        if (d !== 32'h00000804) begin
            failures++;
            $display("FAIL end_bit_status got=%h required=00000804", d);
        end
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_clock();
        test_cmd0_no_resp();
        test_cmd8_resp();
        test_crc_error();
        test_timeout();
        test_busy_writes_and_reset();
        test_r3_and_end_bit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Hardware SD-card command-line transceiver. It replaces software bit-banging of the SD CMD pin with a register-driven engine. Software writes a 32-bit argument and a command index over the Avalon-MM slave. The block frames the 48-bit command with CRC7, shifts it out on CMD against a generated SD clock, optionally captures and checks the 48-bit response, and reports status. It sits between the Avalon fabric and the top-level CMD pad tristate (cmd_out/cmd_oe/cmd_in), plus the SD_CLK pin.

## Interface
- CLK_DIV, 4, clk cycles per sd_clk half-period (≥2).
- RESP_TIMEOUT, 64, sd_clk rising edges allowed between command end bit and response start bit.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- sd_clk  out  1  SD clock, free-running.
- cmd_out  out  1  CMD value to pad.
- cmd_oe  out  1  CMD pad drive enable.
- cmd_in  in  1  CMD value from pad.

## Operation
- Registers:
  - addr 0 ARG: R/W, 32 bits.
  - addr 1 CMD: write only. [5:0] index, [6] resp_en. Reads return 0.
  - addr 2 STATUS: read only.
    - [0] busy.
    - [1] timeout.
    - [2] crc_err.
    - [13:8] received response index.
  - addr 3 RESP: read only. Received response bits [39:8].
- A write to CMD while busy=0 launches a transaction. On launch, timeout and crc_err clear. A CMD write while busy=1 is ignored. An ARG write while busy=1 is ignored.
- Command frame, sent MSB first, 48 bits: 0, 1, index[5:0], ARG[31:0], CRC7[6:0], 1.
- CRC7 uses polynomial x^7+x^3+1 with initial value 0. It covers the first 40 bits.
- State machine:
  - IDLE: cmd_oe=0. On launch, go to SEND.
  - SEND: drive 48 bits, one per sd_clk falling edge. After the end bit has been held for a full sd_clk period, release cmd_oe. Then go to WAIT if resp_en=1, else GAP.
  - WAIT: sample cmd_in on each sd_clk rising edge.
    - Sample 0 → RECV; this sample is response bit 47.
    - After RESP_TIMEOUT rising edges with no 0 seen → set timeout, go to GAP.
  - RECV: shift in 47 further bits on rising edges, then go to GAP. At completion:
    - RESP latches bits [39:8]. STATUS[13:8] latches bits [45:40].
    - crc_err=1 if end bit ≠1.
    - crc_err=1 if index ≠6'h3F and the CRC7 over bits [47:8] ≠ bits [7:1]. Index 6'h3F (R2/R3 style) skips the CRC check.
  - GAP: cmd_oe=0 for 8 sd_clk rising edges, then go to IDLE. busy=0 only in IDLE.
- readdata: every clk, register the mux of the addressed register. Unused bits read 0.

## Timing
- Reset values:
  - readdata=0, sd_clk=0, cmd_out=1, cmd_oe=0.
  - ARG=0, RESP=0, all STATUS bits 0, state IDLE.
- Reset mid-transaction aborts immediately to the reset values. No partial status is kept.
- sd_clk toggles when a divider counter reaches CLK_DIV-1; the counter then wraps to 0. Period is 2·CLK_DIV clk cycles. The clock runs continuously after reset.
- Edges:
  - A fall tick is the clk cycle in which sd_clk goes 1→0. cmd_out and cmd_oe change only on fall ticks.
  - A rise tick is the cycle in which sd_clk goes 0→1. cmd_in is sampled only on rise ticks.
- busy reads 1 starting from the read issued one cycle after the launching write.
- The start bit and cmd_oe=1 appear on the first fall tick after launch.
- cmd_oe=1 lasts exactly 48 sd_clk periods.
- Read latency: readdata is valid one clk after the cycle in which address is presented.

## Test plan
- CMD0, ARG=0, resp_en=0, CLK_DIV=4 → CMD serial is 0x40_00000000_95 over 48 fall ticks. Then 8-period GAP. busy=0 after 56 sd_clk periods. STATUS=0.
- CMD8, ARG=0x000001AA, resp_en=1. Card model replies 0x08_000001AA_13 after 5 rise ticks → frame 0x48_000001AA_87 sent. RESP=0x000001AA, STATUS[13:8]=8, crc_err=0, timeout=0.
- Same as previous, but the model flips one CRC bit in the reply → crc_err=1, RESP still 0x000001AA.
- CMD55, resp_en=1, no reply (cmd_in held 1) → frame 0x77_00000000_65 sent. timeout=1 after 64 rise ticks. busy then clears after GAP.
- During SEND, write CMD=0x11 and ARG=0xDEADBEEF → frame is unaffected and ARG keeps its old value. Then assert reset mid-WAIT → cmd_oe=0, cmd_out=1, readdata=0, STATUS=0 immediately.
- Reply with index 6'h3F and arbitrary CRC bits → crc_err=0. Reply with end bit 0 → crc_err=1.
